// File: rtl/immgen_stage_if.sv
// Fetch-to-decode handshake bundle for immgen_stage: instruction in, immediate/format out.
// Both directions are valid/ready; the stage side is the slave modport.
interface immgen_stage_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_inst;
    logic            o_valid;
    logic            i_ready;
    logic [31:0]     o_inst;
    logic [XLEN-1:0] o_imm;
    logic [2:0]      o_fmt;

    modport slave (
        input  i_valid, i_inst, i_ready,
        output o_ready, o_valid, o_inst, o_imm, o_fmt
    );

    modport master (
        output i_valid, i_inst, i_ready,
        input  o_ready, o_valid, o_inst, o_imm, o_fmt
    );
endinterface

// File: rtl/immgen_stage.sv
// Registered RISC-V immediate generator with 2-entry skid, 1-cycle latency, registered o_ready.
// Macro IMMGEN_ZICSR_EN adds the Z format (CSR*I uimm); otherwise SYSTEM decodes as NONE.
module immgen_stage #(
    parameter int XLEN     = 32,
    parameter int RV64_OPS = 0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_flush,
    immgen_stage_if.slave  bus
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMMGEN_ZICSR_EN
    localparam logic [2:0] FMT_Z    = 3'd6;
`endif

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
`ifdef IMMGEN_ZICSR_EN
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
`endif

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("immgen_stage: XLEN must be 32 or 64");
        end
        if (RV64_OPS != 0 && XLEN != 64) begin : g_bad_rv64
            $error("immgen_stage: RV64_OPS requires XLEN=64");
        end
    endgenerate

    logic [31:0]     w_inst;
    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic            w_is_shift;
    logic [2:0]      w_dec_fmt;
    logic [XLEN-1:0] w_dec_imm;

    assign w_inst     = bus.i_inst;
    assign w_opc      = w_inst[6:0];
    assign w_f3       = w_inst[14:12];
    assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    always_comb begin
        w_dec_fmt = FMT_NONE;
        w_dec_imm = '0;
        case (w_opc)
            OPC_LOAD, OPC_JALR: begin
                w_dec_fmt = FMT_I;
                w_dec_imm = XLEN'($signed(w_inst[31:20]));
            end
            OPC_OPIMM: begin
                w_dec_fmt = FMT_I;
                // Shift immediates are a zero-extended shamt, not a signed constant.
                if (w_is_shift)
                    w_dec_imm = (RV64_OPS != 0) ? XLEN'(w_inst[25:20]) : XLEN'(w_inst[24:20]);
                else
                    w_dec_imm = XLEN'($signed(w_inst[31:20]));
            end
            OPC_OPIMM32: begin
                if (RV64_OPS != 0) begin
                    w_dec_fmt = FMT_I;
                    w_dec_imm = w_is_shift ? XLEN'(w_inst[24:20])
                                           : XLEN'($signed(w_inst[31:20]));
                end
            end
            OPC_STORE: begin
                w_dec_fmt = FMT_S;
                w_dec_imm = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
            end
            OPC_BRANCH: begin
                w_dec_fmt = FMT_B;
                w_dec_imm = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25],
                                           w_inst[11:8], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                w_dec_fmt = FMT_U;
                w_dec_imm = XLEN'($signed({w_inst[31:12], 12'b0}));
            end
            OPC_JAL: begin
                w_dec_fmt = FMT_J;
                w_dec_imm = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20],
                                           w_inst[30:21], 1'b0}));
            end
`ifdef IMMGEN_ZICSR_EN
            OPC_SYSTEM: begin
                if (w_f3[2]) begin
                    w_dec_fmt = FMT_Z;
                    w_dec_imm = XLEN'(w_inst[19:15]);
                end
            end
`endif
            default: begin
                w_dec_fmt = FMT_NONE;
                w_dec_imm = '0;
            end
        endcase
    end

    logic            r_out_vld;
    logic [31:0]     r_out_inst;
    logic [XLEN-1:0] r_out_imm;
    logic [2:0]      r_out_fmt;
    logic            r_skd_vld;
    logic [31:0]     r_skd_inst;
    logic [XLEN-1:0] r_skd_imm;
    logic [2:0]      r_skd_fmt;
    logic            r_rdy;

    logic w_in_xfer;
    logic w_out_load;
    logic w_skd_capture;
    logic w_skd_vld_nxt;

    // r_rdy mirrors !r_skd_vld, so input never arrives while the skid is draining.
    assign w_in_xfer     = bus.i_valid && r_rdy;
    assign w_out_load    = !r_out_vld || bus.i_ready;
    assign w_skd_capture = w_in_xfer && r_out_vld && !bus.i_ready;
    assign w_skd_vld_nxt = !i_flush && (w_skd_capture || (r_skd_vld && !w_out_load));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_vld  <= 1'b0;
            r_out_inst <= '0;
            r_out_imm  <= '0;
            r_out_fmt  <= FMT_NONE;
            r_skd_vld  <= 1'b0;
            r_skd_inst <= '0;
            r_skd_imm  <= '0;
            r_skd_fmt  <= FMT_NONE;
            r_rdy      <= 1'b1;
        end else begin
            r_skd_vld <= w_skd_vld_nxt;
            r_rdy     <= !w_skd_vld_nxt;
            if (w_skd_capture) begin
                r_skd_inst <= w_inst;
                r_skd_imm  <= w_dec_imm;
                r_skd_fmt  <= w_dec_fmt;
            end
            if (i_flush) begin
                r_out_vld <= 1'b0;
            end else if (w_out_load) begin
                if (r_skd_vld) begin
                    r_out_vld  <= 1'b1;
                    r_out_inst <= r_skd_inst;
                    r_out_imm  <= r_skd_imm;
                    r_out_fmt  <= r_skd_fmt;
                end else if (w_in_xfer) begin
                    r_out_vld  <= 1'b1;
                    r_out_inst <= w_inst;
                    r_out_imm  <= w_dec_imm;
                    r_out_fmt  <= w_dec_fmt;
                end else begin
                    r_out_vld  <= 1'b0;
                end
            end
        end
    end

    assign bus.o_ready = r_rdy;
    assign bus.o_valid = r_out_vld;
    assign bus.o_inst  = r_out_inst;
    assign bus.o_imm   = r_out_imm;
    assign bus.o_fmt   = r_out_fmt;

endmodule

// File: tb/tb_immgen_stage.sv
// Drives an RV32 and an RV64 (RV64_OPS=1) instance in lockstep and checks both against
// an occupancy/queue model with an arithmetic immediate decoder.
module tb_immgen_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid;
    logic [31:0] inst;
    logic        rdy;

    always #5 clk = ~clk;

    immgen_stage_if #(.XLEN(32)) if32 ();
    immgen_stage_if #(.XLEN(64)) if64 ();

    assign if32.i_valid = valid;
    assign if32.i_inst  = inst;
    assign if32.i_ready = rdy;
    assign if64.i_valid = valid;
    assign if64.i_inst  = inst;
    assign if64.i_ready = rdy;

    immgen_stage #(.XLEN(32), .RV64_OPS(0)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(if32)
    );
    immgen_stage #(.XLEN(64), .RV64_OPS(1)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(if64)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic [31:0] rnd;
    logic [6:0]  ops[10];
    logic [31:0] bb_inst[4];
    logic [2:0]  bb_fmt[4];
    logic [63:0] bb_imm[4];
    logic [31:0] d_inst[6];
    logic [2:0]  d_fmt[6];
    logic [63:0] d_imm[6];

    // Immediate value computed as a signed integer from the ISA field weights.
    function automatic void decode(input logic [31:0] w, input bit rv64,
                                   output logic [2:0] fmt, output logic [63:0] imm);
        int     s;
        longint v;
        logic [2:0] f3;
        s   = $signed(w);
        f3  = w[14:12];
        fmt = 3'd0;
        v   = 0;
        case (w[6:0])
            7'b0000011, 7'b1100111: begin fmt = 3'd1; v = s >>> 20; end
            7'b0010011: begin
                fmt = 3'd1;
                if (f3 == 3'b001 || f3 == 3'b101) v = rv64 ? w[25:20] : w[24:20];
                else v = s >>> 20;
            end
            7'b0011011: if (rv64) begin
                fmt = 3'd1;
                if (f3 == 3'b001 || f3 == 3'b101) v = w[24:20];
                else v = s >>> 20;
            end
            7'b0100011: begin fmt = 3'd2; v = (s >>> 25) * 32; v += w[11:7]; end
            7'b1100011: begin
                fmt = 3'd3;
                v = w[31] ? -4096 : 0;
                v += w[7] * 64'd2048 + w[30:25] * 64'd32 + w[11:8] * 64'd2;
            end
            7'b0110111, 7'b0010111: begin fmt = 3'd4; s = int'(w & 32'hFFFF_F000); v = s; end
            7'b1101111: begin
                fmt = 3'd5;
                v = w[31] ? -(1 << 20) : 0;
                v += w[19:12] * 64'd4096 + w[20] * 64'd2048 + w[30:21] * 64'd2;
            end
`ifdef IMMGEN_ZICSR_EN
            7'b1110011: if (w[14]) begin fmt = 3'd6; v = w[19:15]; end
`endif
            default: begin fmt = 3'd0; v = 0; end
        endcase
        imm = v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "/v32"},   64'(if32.o_valid), 64'd0);
        chk({tag, "/r32"},   64'(if32.o_ready), 64'd1);
        chk({tag, "/imm32"}, 64'(if32.o_imm),   64'd0);
        chk({tag, "/fmt32"}, 64'(if32.o_fmt),   64'd0);
        chk({tag, "/ins32"}, 64'(if32.o_inst),  64'd0);
        chk({tag, "/v64"},   64'(if64.o_valid), 64'd0);
        chk({tag, "/r64"},   64'(if64.o_ready), 64'd1);
        chk({tag, "/imm64"}, if64.o_imm,        64'd0);
        chk({tag, "/fmt64"}, 64'(if64.o_fmt),   64'd0);
    endtask

    task automatic check_outputs(input string tag);
        logic [2:0]  f;
        logic [63:0] im;
        chk({tag, "/v32"}, 64'(if32.o_valid), 64'(q.size() > 0));
        chk({tag, "/r32"}, 64'(if32.o_ready), 64'(q.size() < 2));
        chk({tag, "/v64"}, 64'(if64.o_valid), 64'(q.size() > 0));
        chk({tag, "/r64"}, 64'(if64.o_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            decode(q[0], 1'b0, f, im);
            chk({tag, "/ins32"}, 64'(if32.o_inst), 64'(q[0]));
            chk({tag, "/fmt32"}, 64'(if32.o_fmt),  64'(f));
            chk({tag, "/imm32"}, 64'(if32.o_imm),  {32'd0, im[31:0]});
            decode(q[0], 1'b1, f, im);
            chk({tag, "/ins64"}, 64'(if64.o_inst), 64'(q[0]));
            chk({tag, "/fmt64"}, 64'(if64.o_fmt),  64'(f));
            chk({tag, "/imm64"}, if64.o_imm,       im);
        end
    endtask

    // One clock: drive, check current outputs, clock, then advance the model.
    task automatic cyc(input logic v, input logic [31:0] w, input logic r, input logic f,
                       input string tag);
        bit in_x;
        bit out_x;
        valid = v; inst = w; rdy = r; flush = f;
        #1;
        check_outputs(tag);
        in_x  = v && (q.size() < 2);
        out_x = (q.size() > 0) && r;
        @(posedge clk);
        #1;
        if (f) q.delete();
        else begin
            if (out_x) void'(q.pop_front());
            if (in_x) q.push_back(w);
        end
    endtask

    initial begin
        ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0011011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b1101111, 7'b1110011, 7'b0110011};
        bb_inst = '{32'h800000B7, 32'hFE112E23, 32'hFE000EE3, 32'hFFDFF0EF};
        bb_fmt  = '{3'd4, 3'd2, 3'd3, 3'd5};
        bb_imm  = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFC,
                    64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC};
        // Values for the RV64 instance: SLLI, ADDIW, SLLIW, CSRRWI, ADD, SRAI.
        d_inst = '{32'h03F09093, 32'h8000009B, 32'h0030909B, 32'h3401D073,
                   32'h002081B3, 32'h4030D093};
        d_fmt  = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1};
        d_imm  = '{64'h3F, 64'hFFFF_FFFF_FFFF_F800, 64'h3, 64'h0, 64'h0, 64'h3};
`ifdef IMMGEN_ZICSR_EN
        d_fmt[3] = 3'd6;
        d_imm[3] = 64'h3;
`endif

        rst = 1'b1; flush = 1'b0; valid = 1'b0; inst = '0; rdy = 1'b0;
        #2;
        check_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();

        cyc(1'b1, 32'hFFF00093, 1'b1, 1'b0, "addi_in");
        chk("addi_fmt32", 64'(if32.o_fmt), 64'd1);
        chk("addi_imm32", 64'(if32.o_imm), 64'h0000_0000_FFFF_FFFF);
        chk("addi_imm64", if64.o_imm,      64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, "addi_out");

        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, bb_inst[i], 1'b1, 1'b0, "b2b");
            chk("b2b_v",     64'(if32.o_valid), 64'd1);
            chk("b2b_fmt32", 64'(if32.o_fmt),   64'(bb_fmt[i]));
            chk("b2b_imm32", 64'(if32.o_imm),   {32'd0, bb_imm[i][31:0]});
            chk("b2b_imm64", if64.o_imm,        bb_imm[i]);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0, "b2b_idle");
        cyc(1'b0, 32'h0, 1'b1, 1'b0, "b2b_idle");

        cyc(1'b1, 32'h00100093, 1'b0, 1'b0, "stall_a");
        cyc(1'b1, 32'h00200113, 1'b0, 1'b0, "stall_b");
        cyc(1'b1, 32'h00300193, 1'b0, 1'b0, "stall_c");
        chk("stall_rdy", 64'(if32.o_ready), 64'd0);
        cyc(1'b1, 32'h00300193, 1'b0, 1'b0, "stall_hold");
        cyc(1'b1, 32'h00300193, 1'b1, 1'b0, "stall_drain");
        cyc(1'b1, 32'h00300193, 1'b1, 1'b0, "stall_c_acc");
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, "stall_tail");

        cyc(1'b1, 32'h00A00093, 1'b0, 1'b0, "flush_a");
        cyc(1'b1, 32'h00B00093, 1'b0, 1'b0, "flush_b");
        cyc(1'b1, 32'h00C00093, 1'b0, 1'b1, "flush_full");
        chk("flush_v",   64'(if32.o_valid), 64'd0);
        chk("flush_rdy", 64'(if64.o_ready), 64'd1);
        cyc(1'b1, 32'h00D00093, 1'b0, 1'b0, "flush_y1");
        cyc(1'b1, 32'h00E00093, 1'b1, 1'b1, "flush_drop");
        for (int i = 0; i < 2; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, "flush_tail");

        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, d_inst[i], 1'b1, 1'b0, "dir");
            chk("dir_fmt64", 64'(if64.o_fmt), 64'(d_fmt[i]));
            chk("dir_imm64", if64.o_imm,      d_imm[i]);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0, "dir_idle");

        for (int i = 0; i < 400; i++) begin
            rnd = $urandom();
            if ($urandom_range(0, 7) == 0)
                cyc($urandom_range(0, 3) != 0, rnd, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0, "rand");
            else
                cyc($urandom_range(0, 3) != 0, {rnd[31:7], ops[$urandom_range(0, 9)]},
                    $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, "rand");
        end

        cyc(1'b1, 32'hFFF00093, 1'b0, 1'b0, "mid_a");
        cyc(1'b1, 32'h800000B7, 1'b0, 1'b0, "mid_b");
        rst = 1'b1;
        #1;
        check_reset("mid_reset");
        q.delete();
        #1;
        rst = 1'b0;
        cyc(1'b0, 32'h0, 1'b1, 1'b0, "post_reset");
        cyc(1'b1, 32'hFE000EE3, 1'b1, 1'b0, "post_reset_in");
        cyc(1'b0, 32'h0, 1'b1, 1'b0, "post_reset_out");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
